// File: rtl/instr_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode_pkg                                                     |
// | Widths, instruction field positions and FSM encodings.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package instr_decode_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int FLAG_W  = 5;
  localparam int IMM_W   = 7;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;

  // Instruction word layout
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int IBIT    = 7;
  localparam int IMM_LSB = 0;
  localparam int PAD_LSB = 4;
  localparam int PAD_W   = 3;
  localparam int RS_LSB  = 0;

  localparam logic [OPC_W-1:0] OPC_RESERVED = 4'hF;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_EXEC    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_DECODE  = ST_DECODE,
    S_EXEC    = ST_EXEC,
    S_CAPTURE = ST_CAPTURE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decode_ctrl_field_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_field_decode                                                   |
// | Combinational split of the instruction register into ALU controls.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_field_decode
  import instr_decode_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_AW_P = REG_AW,
  parameter int IMM_W_P  = IMM_W
) (
  input  logic [INSTR_W-1:0]  ir,
  output logic [REG_AW_P-1:0] rdest,
  output logic [REG_AW_P-1:0] rsrc,
  output logic [OPC_W-1:0]    opcode,
  output logic [DATA_W_P-1:0] imm,
  output logic                imm_s,
  output logic                illegal
);

  logic                w_ibit;
  logic [IMM_W_P-1:0]  w_imm_raw;
  logic [PAD_W-1:0]    w_pad;

  assign w_ibit    = ir[IBIT];
  assign w_imm_raw = ir[IMM_LSB +: IMM_W_P];
  assign w_pad     = ir[PAD_LSB +: PAD_W];

  assign opcode = ir[OPC_LSB +: OPC_W];
  assign rdest  = ir[RD_LSB +: REG_AW_P];
  // Immediate forms operate in place: source register is the destination
  assign rsrc   = w_ibit ? ir[RD_LSB +: REG_AW_P] : ir[RS_LSB +: REG_AW_P];
  assign imm_s  = w_ibit;
  assign imm    = w_ibit ? {{(DATA_W_P-IMM_W_P){w_imm_raw[IMM_W_P-1]}}, w_imm_raw}
                         : '0;

  assign illegal = (opcode == OPC_RESERVED) || (!w_ibit && (w_pad != '0));

endmodule
`default_nettype wire

// File: rtl/instr_decode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_decode_ctrl                                                    |
// | Decodes a 16-bit instruction stream into RegFile_Alu control and     |
// | captures each result. Revision: 1.0                                  |
// +----------------------------------------------------------------------+
module instr_decode_ctrl
  import instr_decode_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_AW_P = REG_AW,
  parameter int FLAG_W_P = FLAG_W,
  parameter int IMM_W_P  = IMM_W
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [INSTR_W-1:0]  InstrIn,
  input  logic                InstrValid,
  output logic                InstrReady,
  output logic [REG_AW_P-1:0] RdestRegLoc,
  output logic [REG_AW_P-1:0] RsrcRegLoc,
  output logic [OPC_W-1:0]    OpCode,
  output logic [DATA_W_P-1:0] Imm,
  output logic                Imm_s,
  output logic                En,
  input  logic [DATA_W_P-1:0] RdestOut,
  input  logic [FLAG_W_P-1:0] Flags,
  output logic [DATA_W_P-1:0] ResultOut,
  output logic [FLAG_W_P-1:0] FlagsOut,
  output logic                ResultValid,
  output logic                Illegal,
  output logic [15:0]         InstrCount
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W_P-1:0] r_result;
  logic [FLAG_W_P-1:0] r_flags;
  logic                r_result_valid;
  logic [15:0]         r_instr_count;
  logic                w_accept;
  logic                w_illegal;

  // Fields come straight from IR, so they hold their last value in IDLE
  instr_field_decode #(
    .DATA_W_P (DATA_W_P),
    .REG_AW_P (REG_AW_P),
    .IMM_W_P  (IMM_W_P)
  ) u_field_decode (
    .ir      (r_ir),
    .rdest   (RdestRegLoc),
    .rsrc    (RsrcRegLoc),
    .opcode  (OpCode),
    .imm     (Imm),
    .imm_s   (Imm_s),
    .illegal (w_illegal)
  );

  assign w_accept = InstrValid && InstrReady;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    InstrReady  = 1'b0;
    En          = 1'b0;
    Illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        InstrReady = 1'b1;
        if (InstrValid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        Illegal     = w_illegal;
        w_state_nxt = w_illegal ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        En          = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ir <= '0;
    end else if (w_accept) begin
      r_ir <= InstrIn;
    end
  end

  // RdestOut already shows the EXEC write while in CAPTURE
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_result       <= '0;
      r_flags        <= '0;
      r_result_valid <= 1'b0;
      r_instr_count  <= '0;
    end else begin
      r_result_valid <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) begin
        r_result      <= RdestOut;
        r_flags       <= Flags;
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign ResultOut   = r_result;
  assign FlagsOut    = r_flags;
  assign ResultValid = r_result_valid;
  assign InstrCount  = r_instr_count;

endmodule
`default_nettype wire

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Instruction-driven controller for RegFile_Alu. It replaces hard-coded control sequencing with decoding of a 16-bit instruction stream.
- Accepts instruction words over a valid/ready handshake and decodes them into RegFile_Alu control fields (RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s, En).
- Sequences one write per instruction, then captures the written result and flags for readback.
- Sits between an instruction source (ROM/sequencer/testbench) and RegFile_Alu.

Parameters:
- DATA_W, 16, datapath/immediate width
- REG_AW, 4, register address width
- FLAG_W, 5, ALU flag width
- IMM_W, 7, raw immediate field width (sign-extended to DATA_W)

Ports:
- Clk  input  1  clock; all state changes on posedge
- Rst  input  1  reset, asynchronous, active-low
- InstrIn  input  16  instruction word
- InstrValid  input  1  InstrIn valid
- InstrReady  output  1  controller can accept an instruction
- RdestRegLoc  output  REG_AW  destination register to RegFile_Alu
- RsrcRegLoc  output  REG_AW  source register to RegFile_Alu
- OpCode  output  4  ALU opcode to RegFile_Alu
- Imm  output  DATA_W  sign-extended immediate
- Imm_s  output  1  1 = use Imm as operand B
- En  output  1  register-file write enable
- RdestOut  input  DATA_W  Rdest readback from RegFile_Alu
- Flags  input  FLAG_W  ALU flags from RegFile_Alu
- ResultOut  output  DATA_W  captured result of last instruction
- FlagsOut  output  FLAG_W  captured flags of last instruction
- ResultValid  output  1  one-cycle pulse when ResultOut/FlagsOut update
- Illegal  output  1  one-cycle pulse on rejected instruction
- InstrCount  output  16  count of executed (legal) instructions, wraps

Behaviour:
- Instruction format:
  - [15:12] OpCode
  - [11:8] Rdest
  - [7] I bit
  - I=1: [6:0] imm7, sign-extended to DATA_W; Imm_s=1; RsrcRegLoc=Rdest
  - I=0: [6:4] must be 000; [3:0] Rsrc; Imm_s=0; Imm=0
- Illegal conditions: OpCode==4'b1111 (reserved), or I=0 with [6:4]!=000.
- FSM states: IDLE, DECODE, EXEC, CAPTURE.
  - IDLE: InstrReady=1, En=0. On InstrValid&InstrReady at posedge, latch InstrIn into IR → DECODE.
  - DECODE: control outputs driven from IR, En=0 (one setup cycle). If illegal: Illegal=1 this cycle → IDLE, no write. Otherwise → EXEC.
  - EXEC: En=1 for exactly one cycle; fields held stable → CAPTURE.
  - CAPTURE: En=0, fields held. At the exiting posedge: ResultOut<=RdestOut, FlagsOut<=Flags, InstrCount++ (wraps 16'hFFFF→0). ResultValid=1 during the cycle after CAPTURE → IDLE.
- Latency and throughput:
  - Accept to En: 2 cycles.
  - Accept to ResultValid: 4 cycles.
  - Maximum throughput: 1 instruction per 4 cycles.
  - InstrReady is low in all states except IDLE.
- Backpressure: InstrValid held high is consumed once per IDLE visit. InstrIn is sampled only at the accepting edge; later changes are ignored.
- Outputs in IDLE: fields hold the last decoded values; En=0 always.
- Reset (Rst=0, any time, including mid-EXEC):
  - Immediately: state=IDLE, En=0, InstrReady=1 once Rst=1.
  - IR=0; RdestRegLoc=RsrcRegLoc=OpCode=0; Imm=0; Imm_s=0.
  - ResultOut=0, FlagsOut=0, ResultValid=0, Illegal=0, InstrCount=0.
  - An instruction in flight is dropped with no write.
- Illegal and ResultValid are never high in the same cycle. En is never high outside EXEC.

Decomposition:
- Package instr_decode_pkg:
  - State encoding constants (IDLE, DECODE, EXEC, CAPTURE)
  - Field bit positions
  - OPC_RESERVED=4'hF
  - Width constants matching the parameters
- Sub-module instr_field_decode: purely combinational. IR → RdestRegLoc, RsrcRegLoc, OpCode, Imm (sign-extended), Imm_s, illegal.
- The top level holds the FSM, IR, capture registers and counter.

Test Plan:
- Reset: Rst low mid-EXEC → En=0 immediately; all outputs zero; InstrReady=1 after release; RegFile_Alu contents unchanged by the dropped instruction.
- Fibonacci with RegFile_Alu attached, stream 0x0081, 0x0181, 0x0001, 0x0100, 0x0001, 0x0100 → ResultOut sequence 1, 1, 2, 3, 5, 8; InstrCount=6; En high exactly 6 cycles.
- Negative immediate: 0x02FF → Imm=16'hFFFF, Imm_s=1, RdestRegLoc=2, RsrcRegLoc=2; with R2=0, ResultOut=16'hFFFF.
- Illegal: 0xF000, then 0x0010 → Illegal pulses twice, En never high, InstrCount unchanged, ResultValid never asserted.
- Backpressure: InstrValid held high with 3 words presented back-to-back, each held until accepted → InstrReady spacing 4 cycles, each word accepted once, 3 ResultValid pulses.
- Counter wrap: preload via 65536 legal instructions (or force) → InstrCount goes 16'hFFFF→16'h0000.
